prio_event_encoder: RTL and testbench

- Parametrised, registered successor to the 8:3 combinational priority encoder.
- Captures single-cycle request pulses from N sources into a sticky pending register.
- Presents them one at a time, highest index first, as an encoded index with valid/ready handshake; the served bit clears on hand-off.
- Sits between interrupt/event sources and a single consumer (controller or FSM).

---
 rtl/prio_event_encoder.sv | 152 +++++++++++++++
 tb/tb_prio_event_encoder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_event_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : prio_event_encoder
//  Purpose  : Sticky event capture with one-at-a-time valid/ready hand-off of
//             the encoded index. Fixed priority (highest index first) by
//             default; define PRIO_EVENT_ENCODER_RR_EN for round-robin.
//  Revision : 1.0  initial release
// ============================================================================
module prio_event_encoder #(
    parameter int  N  = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1,
    localparam int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [IW-1:0] out_idx,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] pend_cnt,
    output logic          ovf,
    input  logic          ovf_clr
);

    logic [N-1:0]  pending_q, pending_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [N-1:0]  cand;
    logic [N-1:0]  sel_mask;
    logic [N-1:0]  pres_mask;
    logic [IW-1:0] sel_idx;
    logic          sel_found;
    logic          slot_free;

`ifdef PRIO_EVENT_ENCODER_RR_EN
    logic [IW-1:0] rr_q, rr_d;
    int            best;
    int            dist;

    // Distance 0 is the index just below the last grant; the last grant itself is farthest.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        best      = N;
        dist      = 0;
        for (int j = 0; j < N; j++) begin
            if (cand[j]) begin
                dist = (int'(rr_q) - j - 1 + 2 * N) % N;
                if (dist < best) begin
                    best      = dist;
                    sel_idx   = IW'(j);
                    sel_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (slot_free && sel_found) begin
            rr_d = sel_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= IW'(N - 1);
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) begin
                sel_idx   = IW'(i);
                sel_found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        slot_free = !valid_q || out_ready;
        cand      = pending_q | req;
        for (int i = 0; i < N; i++) begin
            sel_mask[i]  = sel_found && (sel_idx == IW'(i));
            pres_mask[i] = valid_q && !out_ready && (idx_q == IW'(i));
        end
    end

    always_comb begin
        idx_d     = idx_q;
        valid_d   = valid_q;
        pending_d = pending_q;
        if (slot_free) begin
            if (sel_found) begin
                idx_d   = sel_idx;
                valid_d = 1'b1;
                // A request colliding with a selected pending bit is a fresh event and stays pending.
                pending_d = (cand & ~sel_mask) | (sel_mask & pending_q & req);
            end else begin
                valid_d   = 1'b0;
                pending_d = '0;
            end
        end else begin
            // A request for the stalled presented index merges into it instead of re-pending.
            pending_d = pending_q | (req & ~pres_mask);
        end

        if (|(req & (pending_q | pres_mask))) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        cnt_d = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d = cnt_d + {{(CW-1){1'b0}}, pending_d[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_idx   = idx_q;
    assign out_valid = valid_q;
    assign pend_cnt  = cnt_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_prio_event_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prio_event_encoder
//  Purpose  : Directed vectors with an event-level reference model compared
//             every cycle, plus hand-computed literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prio_event_encoder;

    localparam int N  = 8;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic          out_ready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [IW-1:0] out_idx;
    logic          out_valid;
    logic [CW-1:0] pend_cnt;
    logic          ovf;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    prio_event_encoder #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pend_cnt  (pend_cnt),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    // Reference model: one flag per source for waiting events plus the presented slot.
    bit m_pend[N];
    bit nxt[N];
    int m_idx   = 0;
    bit m_valid = 1'b0;
    bit m_ovf   = 1'b0;
    int m_p     = N - 1;
    int sel;
    bit hit;
    bit stall;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
            m_idx   = 0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_p     = N - 1;
        end else begin
            hit   = 1'b0;
            sel   = -1;
            stall = m_valid && !out_ready;
            for (int i = 0; i < N; i++)
                if (req[i] && (m_pend[i] || (stall && m_idx == i))) hit = 1'b1;
            if (stall) begin
                for (int i = 0; i < N; i++) nxt[i] = m_pend[i] || (req[i] && m_idx != i);
            end else begin
`ifdef PRIO_EVENT_ENCODER_RR_EN
                for (int k = 1; k <= N; k++)
                    if (sel < 0 && (m_pend[(m_p - k + N) % N] || req[(m_p - k + N) % N]))
                        sel = (m_p - k + N) % N;
`else
                for (int i = N - 1; i >= 0; i--)
                    if (sel < 0 && (m_pend[i] || req[i])) sel = i;
`endif
                for (int i = 0; i < N; i++) nxt[i] = m_pend[i] || req[i];
                if (sel >= 0) begin
                    nxt[sel] = m_pend[sel] && req[sel];
                    m_idx    = sel;
                    m_valid  = 1'b1;
                    m_p      = sel;
                end else begin
                    m_valid = 1'b0;
                end
            end
            for (int i = 0; i < N; i++) m_pend[i] = nxt[i];
            if (hit) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model.valid", int'(out_valid), int'(m_valid));
            if (m_valid) chk("model.idx", int'(out_idx), m_idx);
            chk("model.cnt", int'(pend_cnt), m_count());
            chk("model.ovf", int'(ovf), int'(m_ovf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef PRIO_EVENT_ENCODER_RR_EN
    int drain_seq[4] = '{2, 0, 7, 5};
    int hold_seq[9]  = '{6, 5, 4, 3, 2, 1, 0, 7, 6};
`else
    int drain_seq[4] = '{7, 5, 2, 0};
    int hold_seq[9]  = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
`endif

    initial begin
        tick();
        tick();
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        tick();
        chk("reset.valid", int'(out_valid), 0);
        chk("reset.idx", int'(out_idx), 0);
        chk("reset.cnt", int'(pend_cnt), 0);
        chk("reset.ovf", int'(ovf), 0);

        req = 8'h10;
        tick();
        req = '0;
        chk("single.valid", int'(out_valid), 1);
        chk("single.idx", int'(out_idx), 4);
        chk("single.cnt", int'(pend_cnt), 0);
        out_ready = 1'b1;
        tick();
        chk("single.done", int'(out_valid), 0);

        req = 8'hA5;
        for (int k = 0; k < 4; k++) begin
            tick();
            req = '0;
            chk("drain.idx", int'(out_idx), drain_seq[k]);
            chk("drain.cnt", int'(pend_cnt), 3 - k);
        end
        tick();
        chk("drain.done", int'(out_valid), 0);

        out_ready = 1'b0;
        req = 8'h08;
        tick();
        chk("bp.idx", int'(out_idx), 3);
        chk("bp.ovf0", int'(ovf), 0);
        tick();
        chk("bp.ovf1", int'(ovf), 1);
        chk("bp.cnt", int'(pend_cnt), 0);
        chk("bp.hold", int'(out_idx), 3);
        req = '0;
        out_ready = 1'b1;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("bp.clr", int'(ovf), 0);
        chk("bp.once", int'(out_valid), 0);

        out_ready = 1'b0;
        req = 8'hC0;
        tick();
        chk("coll.first", int'(out_idx), 7);
        out_ready = 1'b1;
        req = 8'h40;
        tick();
        chk("coll.six", int'(out_idx), 6);
        chk("coll.pend", int'(pend_cnt), 1);
        tick();
        req = '0;
        chk("coll.again", int'(out_idx), 6);
        chk("coll.kept", int'(pend_cnt), 1);
        tick();
        chk("coll.last", int'(out_idx), 6);
        chk("coll.cnt0", int'(pend_cnt), 0);
        tick();
        chk("coll.done", int'(out_valid), 0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;

        out_ready = 1'b0;
        req = 8'hFF;
        tick();
        req = '0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("areset.valid", int'(out_valid), 0);
        chk("areset.cnt", int'(pend_cnt), 0);
        chk("areset.idx", int'(out_idx), 0);
        chk("areset.ovf", int'(ovf), 0);
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle.valid", int'(out_valid), 0);
        end

        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            ovf_clr = (k == 4);
            tick();
            chk("hold.idx", int'(out_idx), hold_seq[k]);
            if (k >= 1) chk("hold.ovf", int'(ovf), 1);
        end
        req = '0;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("hold.clr", int'(ovf), 0);
        for (int k = 0; k < 10; k++) tick();
        chk("hold.drained", int'(out_valid), 0);

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
